// File: rtl/rpm_pi_controller_pkg.sv
// Shared types and constants for the RPM PI speed loop.
// Holds the FSM state encoding, datapath widths and the error saturator.
package rpm_pi_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ERR    = 3'd1,
        S_INTEG  = 3'd2,
        S_MULT   = 3'd3,
        S_SUM    = 3'd4,
        S_UPDATE = 3'd5
    } state_e;

    localparam int ERR_W   = 16;
    localparam int INT_W   = 24;
    localparam int PROD_W  = 41;
    localparam int DUTY_W  = 16;
    localparam int Q_SHIFT = 8;

    // Squeeze a 33-bit signed difference into the 16-bit signed error range.
    function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [32:0] x);
        if (x > 33'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -33'sd32768) begin
            return 16'sh8000;
        end else begin
            return $signed(x[ERR_W-1:0]);
        end
    endfunction

endpackage

// File: rtl/rpm_pi_controller_pwm_generator.sv
// Free-running PWM generator with a period-boundary duty shadow register.
// The registered output can be forced low immediately.
module pwm_generator
    import rpm_pi_controller_pkg::*;
#(
    parameter logic [DUTY_W-1:0] PERIOD = 16'd5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DUTY_W-1:0] i_duty,
    input  logic              i_force_low,
    output logic              o_pwm
);

    localparam int CNT_W = $clog2(int'(PERIOD));

    logic [CNT_W-1:0]  r_count;
    logic [DUTY_W-1:0] r_active;
    logic              r_pwm;
    logic [DUTY_W-1:0] w_count_ext;
    logic              w_wrap;

    assign w_count_ext = DUTY_W'(r_count);
    assign w_wrap      = (w_count_ext == (PERIOD - 16'd1));

    // Counter, boundary-loaded active duty and registered compare output.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count  <= {CNT_W{1'b0}};
            r_active <= {DUTY_W{1'b0}};
            r_pwm    <= 1'b0;
        end else begin
            r_count <= w_wrap ? {CNT_W{1'b0}} : (r_count + CNT_W'(1));
            if (w_wrap) begin
                r_active <= i_duty;
            end
            r_pwm <= i_force_low ? 1'b0 : (w_count_ext < r_active);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/rpm_pi_controller.sv
// Closed-loop PI speed controller: one correction per RPM measurement strobe,
// producing a duty command that a PWM generator applies at period boundaries.
module rpm_pi_controller
    import rpm_pi_controller_pkg::*;
#(
    parameter logic [15:0] PWM_PERIOD = 16'd5000,
    parameter logic [15:0] KP         = 16'd256,
    parameter logic [15:0] KI         = 16'd32,
    parameter logic [23:0] INT_LIMIT  = 24'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] setpoint_rpm,
    input  logic [31:0] rpm_in,
    input  logic        rpm_valid,
    output logic [15:0] duty,
    output logic        pwm_out,
    output logic        busy,
    output logic        sat,
    output logic        drop
);

    state_e r_state;
    state_e w_next_state;
    logic   r_busy;

    logic [31:0]               r_sp;
    logic [31:0]               r_rpm;
    logic signed [ERR_W-1:0]   r_err;
    logic signed [INT_W-1:0]   r_integ;
    logic signed [PROD_W-1:0]  r_p;
    logic signed [PROD_W-1:0]  r_i;
    logic [DUTY_W-1:0]         r_u;
    logic [DUTY_W-1:0]         r_duty;
    logic                      r_sat_hi;
    logic                      r_sat_lo;
    logic                      r_sat;
    logic                      r_drop;

    logic signed [32:0]        w_err_full;
    logic                      w_hold;
    logic signed [INT_W:0]     w_integ_sum;
    logic signed [INT_W:0]     w_lim;
    logic signed [INT_W:0]     w_neg_lim;
    logic signed [INT_W-1:0]   w_integ_next;
    logic signed [PROD_W-1:0]  w_p;
    logic signed [PROD_W-1:0]  w_i;
    logic signed [PROD_W:0]    w_u_sum;
    logic signed [PROD_W:0]    w_u;
    logic signed [PROD_W:0]    w_period_ext;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic [DUTY_W-1:0]         w_u_clamped;

    // State register; busy is registered from the next state so it tracks the FSM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Next-state sequencing; dropping enable returns to IDLE from anywhere.
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next_state = rpm_valid ? S_ERR : S_IDLE;
                S_ERR:    w_next_state = S_INTEG;
                S_INTEG:  w_next_state = S_MULT;
                S_MULT:   w_next_state = S_SUM;
                S_SUM:    w_next_state = S_UPDATE;
                S_UPDATE: w_next_state = S_IDLE;
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    assign w_err_full   = $signed({1'b0, r_sp}) - $signed({1'b0, r_rpm});
    assign w_hold       = (r_sat_hi && (r_err > 16'sd0)) || (r_sat_lo && (r_err < 16'sd0));
    assign w_integ_sum  = {r_integ[INT_W-1], r_integ} + {{(INT_W+1-ERR_W){r_err[ERR_W-1]}}, r_err};
    assign w_lim        = $signed({1'b0, INT_LIMIT});
    assign w_neg_lim    = -w_lim;
    assign w_p          = $signed({25'd0, KP}) * $signed({{(PROD_W-ERR_W){r_err[ERR_W-1]}}, r_err});
    assign w_i          = $signed({25'd0, KI}) * $signed({{(PROD_W-INT_W){r_integ[INT_W-1]}}, r_integ});
    assign w_u_sum      = {r_p[PROD_W-1], r_p} + {r_i[PROD_W-1], r_i};
    assign w_u          = w_u_sum >>> Q_SHIFT;
    assign w_period_ext = $signed({26'd0, PWM_PERIOD});
    assign w_sat_hi     = (w_u > w_period_ext);
    assign w_sat_lo     = w_u[PROD_W];

    // Integrator clamp and output clamp.
    always_comb begin
        w_integ_next = w_integ_sum[INT_W-1:0];
        w_u_clamped  = w_u[DUTY_W-1:0];
        if (w_integ_sum > w_lim) begin
            w_integ_next = INT_LIMIT;
        end else if (w_integ_sum < w_neg_lim) begin
            w_integ_next = w_neg_lim[INT_W-1:0];
        end else begin
            w_integ_next = w_integ_sum[INT_W-1:0];
        end
        if (w_sat_hi) begin
            w_u_clamped = PWM_PERIOD;
        end else if (w_sat_lo) begin
            w_u_clamped = 16'd0;
        end else begin
            w_u_clamped = w_u[DUTY_W-1:0];
        end
    end

    // Datapath: one pipeline step per FSM state; integrator holds when pushing into saturation.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sp     <= 32'd0;
            r_rpm    <= 32'd0;
            r_err    <= 16'sd0;
            r_integ  <= 24'sd0;
            r_p      <= 41'sd0;
            r_i      <= 41'sd0;
            r_u      <= 16'd0;
            r_duty   <= 16'd0;
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
            r_sat    <= 1'b0;
            r_drop   <= 1'b0;
        end else if (!enable) begin
            r_integ  <= 24'sd0;
            r_duty   <= 16'd0;
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
            r_sat    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= rpm_valid && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (rpm_valid) begin
                        r_sp  <= setpoint_rpm;
                        r_rpm <= rpm_in;
                    end
                end
                S_ERR:   r_err <= sat_err(w_err_full);
                S_INTEG: begin
                    if (!w_hold) begin
                        r_integ <= w_integ_next;
                    end
                end
                S_MULT: begin
                    r_p <= w_p;
                    r_i <= w_i;
                end
                S_SUM: begin
                    r_u      <= w_u_clamped;
                    r_sat_hi <= w_sat_hi;
                    r_sat_lo <= w_sat_lo;
                    r_sat    <= w_sat_hi | w_sat_lo;
                end
                S_UPDATE: r_duty <= r_u;
                default:  r_drop <= 1'b0;
            endcase
        end
    end

    pwm_generator #(
        .PERIOD (PWM_PERIOD)
    ) u_pwm (
        .clock       (clock),
        .reset       (reset),
        .i_duty      (r_duty),
        .i_force_low (~enable),
        .o_pwm       (pwm_out)
    );

    assign duty = r_duty;
    assign busy = r_busy;
    assign sat  = r_sat;
    assign drop = r_drop;

endmodule
